// File: rtl/foo_arb_pkg.sv
// foo_arb_pkg: shared types and defaults for the foo call arbiter.
//   N_REQ_DEF / DATA_W_DEF / MAX_INFLIGHT_DEF : default parameter values
//   ID_W, id_t, data_t                        : requester tag and payload types
//   lock_state_t                              : grant-hold register encoding
//   rr_idx()                                  : round-robin search index helper
package foo_arb_pkg;
    localparam int unsigned N_REQ_DEF        = 4;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned MAX_INFLIGHT_DEF = 4;
    localparam int unsigned ID_W             = $clog2(N_REQ_DEF);

    typedef logic [ID_W-1:0]       id_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    function automatic int unsigned rr_idx(int unsigned base, int unsigned k, int unsigned n);
        return (base + k) % n;
    endfunction
endpackage

// File: rtl/foo_tag_fifo.sv
// foo_tag_fifo: in-order FIFO of requester tags for calls issued to foo.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write din when not full
//   pop, dout    : drop head when not empty; dout shows the head
//   count        : entries held (0..DEPTH)
//   full, empty  : status flags
// Same-cycle push and pop are both honoured.
module foo_tag_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_q];
    assign count   = cnt_q;

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/foo_call_arbiter.sv
// foo_call_arbiter: shares one foo instance among N_REQ requesters.
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready/req_data : per-requester call channel (ready one-hot)
//   rsp_valid/rsp_ready/rsp_data : per-requester return channel (data broadcast)
//   foo_start/foo_busy/foo_t     : call interface to foo
//   foo_done/foo_stall/foo_returndata : return interface from foo
//   inflight                     : calls issued and not yet returned
//   err_done                     : sticky, foo_done seen with nothing outstanding
//
// Lock state table:
//   state     | meaning
//   LOCK_FREE | grant chosen round-robin from rr_ptr
//   LOCK_HELD | foo was busy on a presented call; grant pinned to lock_id
module foo_call_arbiter
    import foo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ        = N_REQ_DEF,
    parameter  int unsigned DATA_W       = DATA_W_DEF,
    parameter  int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    localparam int unsigned IDW          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned CW           = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    foo_start,
    input  logic                    foo_busy,
    output logic [DATA_W-1:0]       foo_t,
    input  logic                    foo_done,
    output logic                    foo_stall,
    input  logic [DATA_W-1:0]       foo_returndata,
    output logic [CW-1:0]           inflight,
    output logic                    err_done
);
    lock_state_t    lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           err_q, err_d;

    logic [IDW-1:0] gnt, head;
    logic [CW-1:0]  count;
    logic           full, empty;
    logic           start_raw, accept, stall_raw, ret;
    logic           found;
    int unsigned    idx;

    foo_tag_fifo #(.DEPTH(MAX_INFLIGHT), .WIDTH(IDW)) u_tags (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .pop   (ret),
        .din   (gnt),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        gnt   = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q == LOCK_HELD) begin
            gnt = lock_id_q;
        end else begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                idx = rr_idx(int'(rr_ptr_q), k, N_REQ);
                if (!found && req_valid[idx]) begin
                    gnt   = IDW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Full blocks a push even when a pop happens in the same cycle.
    assign start_raw = ~full & req_valid[gnt];
    assign accept    = start_raw & ~foo_busy & ~reset;
    assign stall_raw = ~empty & ~rsp_ready[head];
    assign ret       = foo_done & ~empty & rsp_ready[head] & ~reset;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        err_d     = err_q;
        if (start_raw && foo_busy) begin
            lock_d    = LOCK_HELD;
            lock_id_d = gnt;
        end
        if (accept) begin
            lock_d   = LOCK_FREE;
            rr_ptr_d = (int'(gnt) == int'(N_REQ) - 1) ? '0 : gnt + 1'b1;
        end
        if (empty && foo_done) err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q    <= LOCK_FREE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    // Every output is forced low while reset is asserted, including paths
    // that would otherwise pass requester/foo inputs straight through.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (!reset) begin
            req_ready[gnt] = accept;
            if (!empty) rsp_valid[head] = foo_done;
        end
        foo_start = start_raw & ~reset;
        foo_t     = reset ? '0 : req_data[int'(gnt)*DATA_W +: DATA_W];
        foo_stall = stall_raw & ~reset;
        rsp_data  = reset ? '0 : foo_returndata;
        inflight  = reset ? '0 : count;
        err_done  = err_q & ~reset;
    end
endmodule
